// File: rtl/pad_input_filter.sv
// rtl/pad_input_filter.sv - pad synchroniser, glitch qualifier, edge strobes
// Optional saturating edge counter is built when PAD_INPUT_FILTER_COUNT_EN is defined.
module pad_input_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_W    = 8,
  parameter int   CNT_W       = 16,
  parameter logic IDLE_VAL    = 1'b1,
  parameter int   COUNT_SEL   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pad_in,
  input  logic [FILTER_W-1:0] filter_len,
  output logic                level,
  output logic                rise,
  output logic                fall,
  input  logic                count_clr,
  output logic [CNT_W-1:0]    edge_count
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [FILTER_W-1:0]    qcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // The >= compare accepts before qcnt can wrap, even if filter_len drops mid-count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= IDLE_VAL;
      qcnt  <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == level) begin
        qcnt <= '0;
      end else if (qcnt >= filter_len) begin
        level <= sync;
        qcnt  <= '0;
        rise  <= sync;
        fall  <= ~sync;
      end else begin
        qcnt <= qcnt + 1'b1;
      end
    end
  end

`ifdef PAD_INPUT_FILTER_COUNT_EN
  logic counted;

  always_comb begin
    counted = 1'b0;
    case (COUNT_SEL)
      0:       counted = rise;
      1:       counted = fall;
      default: counted = rise | fall;
    endcase
  end

  // Clear wins over a coincident edge; the count holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_count <= '0;
    end else if (count_clr) begin
      edge_count <= '0;
    end else if (counted && (edge_count != {CNT_W{1'b1}})) begin
      edge_count <= edge_count + 1'b1;
    end
  end
`else
  logic unused_count_clr;

  assign edge_count       = '0;
  assign unused_count_clr = count_clr ^ (COUNT_SEL == 0);
`endif

endmodule
